// File: rtl/rx_engine.sv
// UART receive engine: 2-flop synchronized RX, mid-bit sampling with a K+1 clock bit
// time, 7/8-bit frames with optional even/odd parity, sticky parity/framing/overrun flags.
module rx_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        eight,
    input  logic        parity,
    input  logic        OHEL,
    input  logic [18:0] K,
    input  logic        CLR_RDY,
    input  logic        CLR_ERR,
    output logic        RXRDY,
    output logic [7:0]  UART_RDATA,
    output logic        PERR,
    output logic        FERR,
    output logic        OVF
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t      state_q;
    logic        rx_meta_q;
    logic        rxs_q;
    logic [18:0] btc_q;
    logic [3:0]  sc_q;
    logic [9:0]  sr_q;
    logic        done_q;

    logic        rxrdy_q;
    logic [7:0]  rdata_q;
    logic        perr_q;
    logic        ferr_q;
    logic        ovf_q;

    logic        htu;
    logic        btu;
    logic [3:0]  n_shifts;
    logic [3:0]  sc_inc;
    logic [7:0]  data_d;
    logic        par_bit;
    logic        exp_par;
    logic        perr_hit;
    logic        ferr_hit;

    assign htu      = (btc_q == (K >> 1));
    assign btu      = (btc_q == K);
    assign n_shifts = 4'd8 + {3'b000, eight} + {3'b000, parity};
    assign sc_inc   = sc_q + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
        end
    end

    // Frame FSM: start bit is qualified at mid-bit, then every K+1 clocks one bit is shifted in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            btc_q   <= 19'd0;
            sc_q    <= 4'd0;
            sr_q    <= 10'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    btc_q <= 19'd0;
                    sc_q  <= 4'd0;
                    if (!rxs_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (htu) begin
                        btc_q   <= 19'd0;
                        state_q <= rxs_q ? IDLE : DATA;
                    end else begin
                        btc_q <= btc_q + 19'd1;
                    end
                end
                DATA: begin
                    if (btu) begin
                        btc_q <= 19'd0;
                        sr_q  <= {rxs_q, sr_q[9:1]};
                        sc_q  <= sc_inc;
                        if (sc_inc == n_shifts) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        btc_q <= btc_q + 19'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Field positions depend on how many shifts the frame took; the stop bit always ends in SR[9].
    always_comb begin
        data_d  = 8'h00;
        par_bit = 1'b0;
        case ({eight, parity})
            2'b00: data_d = {1'b0, sr_q[8:2]};
            2'b01: begin
                data_d  = {1'b0, sr_q[7:1]};
                par_bit = sr_q[8];
            end
            2'b10: data_d = sr_q[8:1];
            default: begin
                data_d  = sr_q[7:0];
                par_bit = sr_q[8];
            end
        endcase
    end

    assign exp_par  = (^data_d) ^ OHEL;
    assign perr_hit = parity & (par_bit != exp_par);
    assign ferr_hit = ~sr_q[9];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxrdy_q <= 1'b0;
            rdata_q <= 8'h00;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (done_q) begin
                rdata_q <= data_d;
                rxrdy_q <= 1'b1;
            end else if (CLR_RDY) begin
                rxrdy_q <= 1'b0;
            end
            perr_q <= (perr_q & ~CLR_ERR) | (done_q & perr_hit);
            ferr_q <= (ferr_q & ~CLR_ERR) | (done_q & ferr_hit);
            ovf_q  <= (ovf_q  & ~CLR_ERR) | (done_q & rxrdy_q);
        end
    end

    assign RXRDY      = rxrdy_q;
    assign UART_RDATA = rdata_q;
    assign PERR       = perr_q;
    assign FERR       = ferr_q;
    assign OVF        = ovf_q;

endmodule

// File: tb/tb_rx_engine.sv
// Directed bench for rx_engine: frames are serialised by the bench at K=15 (16 clocks/bit)
// and the received byte and flags are compared with hand-computed values.
module tb_rx_engine;

    logic        clk;
    logic        rst;
    logic        RX;
    logic        eight;
    logic        parity;
    logic        OHEL;
    logic [18:0] K;
    logic        CLR_RDY;
    logic        CLR_ERR;
    logic        RXRDY;
    logic [7:0]  UART_RDATA;
    logic        PERR;
    logic        FERR;
    logic        OVF;

    int checks   = 0;
    int failures = 0;

    localparam int BIT_CLKS = 16;

    rx_engine dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .eight      (eight),
        .parity     (parity),
        .OHEL       (OHEL),
        .K          (K),
        .CLR_RDY    (CLR_RDY),
        .CLR_ERR    (CLR_ERR),
        .RXRDY      (RXRDY),
        .UART_RDATA (UART_RDATA),
        .PERR       (PERR),
        .FERR       (FERR),
        .OVF        (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        RX = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        int nb;
        nb = eight ? 8 : 7;
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (parity) drive_bit(par_bit);
        drive_bit(stop_bit);
        RX = 1'b1;
    endtask

    task automatic pulse_clr_rdy();
        CLR_RDY = 1'b1;
        idle(1);
        CLR_RDY = 1'b0;
    endtask

    task automatic pulse_clr_err();
        CLR_ERR = 1'b1;
        idle(1);
        CLR_ERR = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic [7:0] d,
                             input logic pe, input logic fe, input logic ov);
        check({tag, ".rdy"},  RXRDY, rdy);
        check({tag, ".data"}, UART_RDATA, d);
        check({tag, ".perr"}, PERR, pe);
        check({tag, ".ferr"}, FERR, fe);
        check({tag, ".ovf"},  OVF, ov);
    endtask

    initial begin
        logic [7:0] vals [3];
        logic [7:0] exp_d;
        logic       p;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        vals[2] = 8'h80;

        rst = 1'b0; RX = 1'b1; eight = 1'b1; parity = 1'b0; OHEL = 1'b0;
        K = 19'd15; CLR_RDY = 1'b0; CLR_ERR = 1'b0;
        idle(3);
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(5);

        // 8N1, 0xA5
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        check_all("a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        pulse_clr_rdy();
        idle(1);
        check("a5.clr_rdy", RXRDY, 1'b0);

        // 7E1, 0x55 has four ones -> even parity bit 0
        eight = 1'b0; parity = 1'b1; OHEL = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        check_all("55e_ok", 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        pulse_clr_rdy();
        send_frame(8'h55, 1'b1, 1'b1);
        idle(20);
        check_all("55e_bad", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        pulse_clr_rdy();
        idle(40);
        check("perr_sticky", PERR, 1'b1);
        pulse_clr_err();
        idle(1);
        check("perr_clr", PERR, 1'b0);

        // 8O1, 0x03 has two ones -> odd parity bit 1
        eight = 1'b1; parity = 1'b1; OHEL = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1);
        idle(20);
        check_all("03o", 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        pulse_clr_rdy();

        // Transmit-engine style frames in every {eight, parity, OHEL} mode
        for (int m = 0; m < 8; m++) begin
            eight = m[2]; parity = m[1]; OHEL = m[0];
            for (int v = 0; v < 3; v++) begin
                exp_d = eight ? vals[v] : (vals[v] & 8'h7F);
                p = (^exp_d) ^ OHEL;
                send_frame(vals[v], p, 1'b1);
                idle(20);
                check_all($sformatf("mode%0d_v%02h", m, vals[v]), 1'b1, exp_d, 1'b0, 1'b0, 1'b0);
                pulse_clr_rdy();
            end
        end

        // Framing error, then a short low pulse that must be rejected as a false start
        eight = 1'b1; parity = 1'b0; OHEL = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(30);
        check_all("3c_ferr", 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
        pulse_clr_rdy();
        idle(2);
        RX = 1'b0;
        idle(5);
        RX = 1'b1;
        idle(40);
        check("false.rdy", RXRDY, 1'b0);
        check("false.data", UART_RDATA, 8'h3C);
        pulse_clr_err();
        idle(1);
        check("ferr_clr", FERR, 1'b0);

        // Back-to-back frames with no read in between
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle(20);
        check_all("ovf", 1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        pulse_clr_err();
        idle(1);
        check("ovf_clr", OVF, 1'b0);
        check("ovf_clr.rdy", RXRDY, 1'b1);

        // Reset in the middle of the data bits
        RX = 1'b0;
        idle(BIT_CLKS);
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle(3);
        rst = 1'b0;
        RX = 1'b1;
        idle(3);
        check_all("midrst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(5);
        send_frame(8'h5A, 1'b0, 1'b1);
        idle(20);
        check_all("after_rst", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/rx_engine.md
# rx_engine

UART receive engine: the serial-to-parallel counterpart of the transmit engine in the UART block. It recovers 7- or 8-bit frames from the asynchronous RX line, with optional even/odd parity. Its frame format and bit time (K) match the transmit engine exactly. It presents each received byte with a ready flag and parity, framing and overrun error flags to the processor-side read logic.

## Interface
- No parameters. The bit time comes from the K port, shared with the transmit engine.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- RX  input  1  serial line; idle high; asynchronous to clk.
- eight  input  1  1 = 8 data bits, 0 = 7 data bits.
- parity  input  1  1 = parity bit present after the data bits.
- OHEL  input  1  parity sense: 0 = even, 1 = odd.
- K  input  19  bit-time terminal count; bit period = K+1 clocks.
- CLR_RDY  input  1  one-clock pulse from the read decode; clears RXRDY.
- CLR_ERR  input  1  one-clock pulse; clears PERR, FERR and OVF.
- RXRDY  output  1  received byte available; reset 0.
- UART_RDATA  output  8  received byte; bit 7 forced to 0 in 7-bit mode; reset 8'h00.
- PERR  output  1  parity error, sticky; reset 0.
- FERR  output  1  framing error (stop bit = 0), sticky; reset 0.
- OVF  output  1  overrun, sticky; reset 0.

## Operation
- RX passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value, rxs.
- 19-bit bit-time counter BTC. HTU = (BTC == K>>1). BTU = (BTC == K).
- BTC is held at 0 in IDLE and cleared on HTU (in START) or on BTU (in DATA); otherwise it increments.
- 4-bit shift counter SC.
- 10-bit shift register SR; on each DATA-state BTU, SR <= {rxs, SR[9:1]}.
- Shift count required for a frame: N = 8 + eight + parity (8, 9 or 10), covering data, parity and stop.
- States:
  - IDLE: SC = 0. rxs == 0 → START.
  - START: on HTU, rxs == 0 → DATA (start bit confirmed at mid-bit). On HTU, rxs == 1 → IDLE (false start, nothing reported).
  - DATA: on each BTU, shift and SC++. The BTU that makes SC == N produces a DONE pulse and → IDLE.
- Field extraction at DONE, by {eight, parity}:
  - 00: data = {0, SR[8:2]}, stop = SR[9].
  - 01: data = {0, SR[7:1]}, par = SR[8], stop = SR[9].
  - 10: data = SR[8:1], stop = SR[9].
  - 11: data = SR[7:0], par = SR[8], stop = SR[9].
- Expected parity: ^data[6:0] (7-bit) or ^data[7:0] (8-bit), inverted when OHEL = 1. This matches the transmit engine.
- On the cycle after DONE:
  - UART_RDATA <= data and RXRDY <= 1.
  - PERR |= parity & (par != expected).
  - FERR |= ~stop.
  - OVF |= RXRDY (previous byte never read).
- CLR_RDY clears RXRDY. CLR_ERR clears all three error flags. If DONE and a clear coincide, the set wins.
- A frame ending with stop = 0 still loads data and sets FERR. The low line then re-triggers START from IDLE.
- eight, parity, OHEL and K must be static during a frame; changing them mid-frame gives undefined data, but the state machine always returns to IDLE.
- rst low at any time, including mid-frame: state → IDLE, counters and SR → 0, synchronizer → 1, all outputs → reset values.

## Timing
- Start is detected 2 clocks after the RX falling edge (synchronizer delay).
- The start bit is sampled (K>>1)+1 clocks after entering START. Each later sample follows the previous one by K+1 clocks, so every sample lands within ±1 clock of mid-bit.
- RXRDY and UART_RDATA update 1 clock after the stop-bit sample, which is mid-stop-bit. Nothing is reported on a false start.
- The engine re-arms immediately after DONE and accepts back-to-back frames with a single stop bit.
- Clear pulses take effect on the next clock edge.

## Test plan
- K=15, eight=1, parity=0; send 0xA5, stop=1 → UART_RDATA=0xA5, RXRDY=1, PERR=FERR=OVF=0; CLR_RDY → RXRDY=0.
- eight=0, parity=1, OHEL=0; send 0x55 with parity 0 → data 0x55, PERR=0. Resend with parity 1 → PERR=1, which holds until CLR_ERR.
- eight=1, parity=1, OHEL=1; send 0x03 with parity 1 → data 0x03, PERR=0. Loop back from the transmit engine for 0x00, 0xFF and 0x80 in all 8 {eight, parity, OHEL} modes → data matches and no flags are set.
- Send 0x3C with stop bit 0 → FERR=1 and data 0x3C. Then hold RX low for 5 clocks, high → false start: RXRDY stays unchanged and no new data is loaded.
- Send 0x11 then 0x22 without CLR_RDY → UART_RDATA=0x22, OVF=1. CLR_ERR → OVF=0.
- Assert rst low mid-DATA → all outputs 0, state IDLE. Release and send 0x5A → received correctly.
